atm_controller: RTL and testbench

//  ATM transaction controller driven by the team's ATM stimulus bench. Accepts a card, collects a
//  4-digit BCD PIN one digit per strobe and compares it with the card PIN. It then runs one deposit
//  or withdrawal against an internal balance register. Locks after 3 wrong PINs until reset.

---
 rtl/atm_controller.sv | 176 +++++++++++++++++
 tb/tb_atm_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_controller.sv
// ATM transaction controller: card insertion, 4-digit BCD PIN check with lockout,
// then one deposit or withdrawal against an internal 64-bit balance.
module atm_controller #(
    parameter logic [63:0] BALANCE_INIT = 64'd0,
    parameter int unsigned MAX_INTENTOS = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        TARJETA_RECIBIDA,
    input  logic [15:0] PIN,
    input  logic [3:0]  DIGITO,
    input  logic        DIGITO_STB,
    input  logic        TIPO_TRANS,
    input  logic        TIPO_STB,
    input  logic [31:0] MONTO,
    input  logic        MONTO_STB,
    output logic        BALANCE_ACTUALIZADO,
    output logic        ENTREGAR_DINERO,
    output logic        FONDOS_INSUFICIENTES,
    output logic        PIN_INCORRECTO,
    output logic        ADVERTENCIA,
    output logic        BLOQUEO,
    output logic [63:0] BALANCE
);

    localparam logic [3:0] MAX_ATT  = 4'(MAX_INTENTOS);
    localparam logic [3:0] WARN_ATT = 4'(MAX_INTENTOS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PIN, S_TIPO, S_MONTO, S_FIN, S_BLOQ
    } state_t;

    state_t      state, state_d;
    logic        dig_stb_q, dig_stb_qq, tipo_stb_q, tipo_stb_qq, monto_stb_q, monto_stb_qq;
    logic [3:0]  dig_q;
    logic        tipo_q, tipo_sel, tipo_sel_d;
    logic [31:0] monto_q;
    logic [15:0] shift, shift_d;
    logic [1:0]  dig_cnt, dig_cnt_d;
    logic [3:0]  att, att_d;
    logic [63:0] bal_d;
    logic        upd_d, ent_d, fon_d, pin_d, adv_d, blq_d;
    logic        dig_ev, tipo_ev, monto_ev;
    logic [15:0] pin_full;
    logic [3:0]  att_inc;
    logic [63:0] monto_ext;

    assign dig_ev    = dig_stb_q & ~dig_stb_qq;
    assign tipo_ev   = tipo_stb_q & ~tipo_stb_qq;
    assign monto_ev  = monto_stb_q & ~monto_stb_qq;
    assign pin_full  = {shift[11:0], dig_q};
    assign att_inc   = att + 4'd1;
    assign monto_ext = {32'b0, monto_q};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state                <= S_IDLE;
            dig_stb_q            <= 1'b0;
            dig_stb_qq           <= 1'b0;
            tipo_stb_q           <= 1'b0;
            tipo_stb_qq          <= 1'b0;
            monto_stb_q          <= 1'b0;
            monto_stb_qq         <= 1'b0;
            dig_q                <= '0;
            tipo_q               <= 1'b0;
            monto_q              <= '0;
            tipo_sel             <= 1'b0;
            shift                <= '0;
            dig_cnt              <= '0;
            att                  <= '0;
            BALANCE              <= BALANCE_INIT;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            ADVERTENCIA          <= 1'b0;
            BLOQUEO              <= 1'b0;
        end else begin
            state                <= state_d;
            dig_stb_q            <= DIGITO_STB;
            dig_stb_qq           <= dig_stb_q;
            tipo_stb_q           <= TIPO_STB;
            tipo_stb_qq          <= tipo_stb_q;
            monto_stb_q          <= MONTO_STB;
            monto_stb_qq         <= monto_stb_q;
            dig_q                <= DIGITO;
            tipo_q               <= TIPO_TRANS;
            monto_q              <= MONTO;
            tipo_sel             <= tipo_sel_d;
            shift                <= shift_d;
            dig_cnt              <= dig_cnt_d;
            att                  <= att_d;
            BALANCE              <= bal_d;
            BALANCE_ACTUALIZADO  <= upd_d;
            ENTREGAR_DINERO      <= ent_d;
            FONDOS_INSUFICIENTES <= fon_d;
            PIN_INCORRECTO       <= pin_d;
            ADVERTENCIA          <= adv_d;
            BLOQUEO              <= blq_d;
        end
    end

    always_comb begin
        state_d    = state;
        shift_d    = shift;
        dig_cnt_d  = dig_cnt;
        att_d      = att;
        bal_d      = BALANCE;
        tipo_sel_d = tipo_sel;
        upd_d      = 1'b0;
        ent_d      = 1'b0;
        fon_d      = 1'b0;
        pin_d      = 1'b0;
        blq_d      = BLOQUEO;

        // Card removal takes priority over any strobe edge seen in the same cycle.
        if (state != S_BLOQ && !TARJETA_RECIBIDA) begin
            state_d   = S_IDLE;
            dig_cnt_d = '0;
            att_d     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_d   = S_PIN;
                    dig_cnt_d = '0;
                    shift_d   = '0;
                end
                S_PIN: begin
                    if (dig_ev) begin
                        shift_d   = pin_full;
                        dig_cnt_d = dig_cnt + 2'd1;
                        if (dig_cnt == 2'd3) begin
                            if (pin_full == PIN) begin
                                att_d   = '0;
                                state_d = S_TIPO;
                            end else begin
                                pin_d = 1'b1;
                                att_d = att_inc;
                                if (att_inc == MAX_ATT) begin
                                    state_d = S_BLOQ;
                                    blq_d   = 1'b1;
                                end
                            end
                        end
                    end
                end
                S_TIPO: begin
                    if (tipo_ev) begin
                        tipo_sel_d = tipo_q;
                        state_d    = S_MONTO;
                    end
                end
                S_MONTO: begin
                    if (monto_ev) begin
                        state_d = S_FIN;
                        if (!tipo_sel) begin
                            bal_d = BALANCE + monto_ext;
                            upd_d = 1'b1;
                        end else if (monto_ext <= BALANCE) begin
                            bal_d = BALANCE - monto_ext;
                            upd_d = 1'b1;
                            ent_d = 1'b1;
                        end else begin
                            fon_d = 1'b1;
                        end
                    end
                end
                S_FIN, S_BLOQ: ;
                default: state_d = S_IDLE;
            endcase
        end

        adv_d = (att_d == WARN_ATT) && (state_d != S_BLOQ);
    end

endmodule

// File: tb/tb_atm_controller.sv
// Directed self-checking bench for atm_controller (default parameters, card PIN 5916).
module tb_atm_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        TARJETA_RECIBIDA = 1'b0;
    logic [15:0] PIN = 16'h5916;
    logic [3:0]  DIGITO = '0;
    logic        DIGITO_STB = 1'b0;
    logic        TIPO_TRANS = 1'b0;
    logic        TIPO_STB = 1'b0;
    logic [31:0] MONTO = '0;
    logic        MONTO_STB = 1'b0;
    logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES;
    logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO;
    logic [63:0] BALANCE;

    int checks = 0;
    int errors = 0;
    int n_upd = 0, n_ent = 0, n_fon = 0, n_pin = 0, n_both = 0;

    atm_controller #(.BALANCE_INIT(64'd0), .MAX_INTENTOS(3)) dut (
        .Clk(Clk), .Reset(Reset), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .PIN(PIN),
        .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS), .TIPO_STB(TIPO_STB),
        .MONTO(MONTO), .MONTO_STB(MONTO_STB), .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO(ENTREGAR_DINERO), .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES),
        .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
        .BALANCE(BALANCE)
    );

    always #5 Clk = ~Clk;

    // Pulse counters sampled just after each rising edge.
    always @(posedge Clk) begin
        #1;
        if (BALANCE_ACTUALIZADO === 1'b1) n_upd++;
        if (ENTREGAR_DINERO === 1'b1) n_ent++;
        if (FONDOS_INSUFICIENTES === 1'b1) n_fon++;
        if (PIN_INCORRECTO === 1'b1) n_pin++;
        if (ENTREGAR_DINERO === 1'b1 && FONDOS_INSUFICIENTES === 1'b1) n_both++;
    end

    task automatic send_digit(input logic [3:0] d);
        @(negedge Clk); DIGITO = d; DIGITO_STB = 1'b1;
        @(negedge Clk); DIGITO_STB = 1'b0;
        @(negedge Clk);
    endtask

    task automatic hold_digit(input logic [3:0] d, input int n);
        @(negedge Clk); DIGITO = d; DIGITO_STB = 1'b1;
        repeat (n) @(negedge Clk);
        DIGITO_STB = 1'b0;
        @(negedge Clk);
    endtask

    task automatic send_pin(input logic [15:0] p);
        for (int i = 0; i < 4; i++) send_digit(p[15-4*i -: 4]);
    endtask

    task automatic send_tipo(input logic t);
        @(negedge Clk); TIPO_TRANS = t; TIPO_STB = 1'b1;
        @(negedge Clk); TIPO_STB = 1'b0;
        @(negedge Clk);
    endtask

    task automatic send_monto(input logic [31:0] m);
        @(negedge Clk); MONTO = m; MONTO_STB = 1'b1;
        @(negedge Clk); MONTO_STB = 1'b0;
        @(negedge Clk);
    endtask

    task automatic insert_card();
        @(negedge Clk); TARJETA_RECIBIDA = 1'b1;
        @(negedge Clk);
    endtask

    task automatic remove_card();
        @(negedge Clk); TARJETA_RECIBIDA = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
             ADVERTENCIA, BLOQUEO} !== 6'b0 || BALANCE !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b balance=%0d, required flags=000000 balance=0",
                     {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
                      ADVERTENCIA, BLOQUEO}, BALANCE);
        end
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_deposit();
        int u0;
        u0 = n_upd;
        insert_card(); send_pin(16'h5916); send_tipo(1'b0); send_monto(32'd10000);
        checks++;
        if (BALANCE_ACTUALIZADO !== 1'b1 || ENTREGAR_DINERO !== 1'b0 || BALANCE !== 64'd10000) begin
            errors++;
            $display("FAIL deposit: upd=%b ent=%b balance=%0d, required upd=1 ent=0 balance=10000",
                     BALANCE_ACTUALIZADO, ENTREGAR_DINERO, BALANCE);
        end
        @(negedge Clk);
        checks++;
        if (BALANCE_ACTUALIZADO !== 1'b0 || n_upd - u0 != 1) begin
            errors++;
            $display("FAIL deposit_pulse_width: upd=%b pulses=%0d, required upd=0 pulses=1",
                     BALANCE_ACTUALIZADO, n_upd - u0);
        end
        remove_card();
    endtask

    task automatic test_withdraw_ok();
        insert_card(); send_pin(16'h5916); send_tipo(1'b1); send_monto(32'd9000);
        checks++;
        if (BALANCE_ACTUALIZADO !== 1'b1 || ENTREGAR_DINERO !== 1'b1 ||
            FONDOS_INSUFICIENTES !== 1'b0 || BALANCE !== 64'd1000) begin
            errors++;
            $display("FAIL withdraw_ok: upd=%b ent=%b fon=%b balance=%0d, required 1 1 0 balance=1000",
                     BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, BALANCE);
        end
        remove_card();
    endtask

    task automatic test_withdraw_nsf();
        insert_card(); send_pin(16'h5916); send_tipo(1'b1); send_monto(32'd2000);
        checks++;
        if (BALANCE_ACTUALIZADO !== 1'b0 || ENTREGAR_DINERO !== 1'b0 ||
            FONDOS_INSUFICIENTES !== 1'b1 || BALANCE !== 64'd1000) begin
            errors++;
            $display("FAIL withdraw_nsf: upd=%b ent=%b fon=%b balance=%0d, required 0 0 1 balance=1000",
                     BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, BALANCE);
        end
        remove_card();
    endtask

    task automatic test_lockout();
        int p0;
        p0 = n_pin;
        insert_card();
        send_pin(16'h4916);
        checks++;
        if (PIN_INCORRECTO !== 1'b1 || ADVERTENCIA !== 1'b0) begin
            errors++;
            $display("FAIL wrong_pin_1: pin_inc=%b adv=%b, required pin_inc=1 adv=0",
                     PIN_INCORRECTO, ADVERTENCIA);
        end
        send_pin(16'h5917);
        checks++;
        if (ADVERTENCIA !== 1'b1 || n_pin - p0 != 2) begin
            errors++;
            $display("FAIL wrong_pin_2: adv=%b pulses=%0d, required adv=1 pulses=2",
                     ADVERTENCIA, n_pin - p0);
        end
        send_pin(16'h5316);
        checks++;
        if (BLOQUEO !== 1'b1 || ADVERTENCIA !== 1'b0) begin
            errors++;
            $display("FAIL block: bloqueo=%b adv=%b, required bloqueo=1 adv=0", BLOQUEO, ADVERTENCIA);
        end
        remove_card();
        insert_card(); send_pin(16'h5916);
        checks++;
        if (BLOQUEO !== 1'b1 || n_pin - p0 != 3) begin
            errors++;
            $display("FAIL block_sticky: bloqueo=%b pulses=%0d, required bloqueo=1 pulses=3",
                     BLOQUEO, n_pin - p0);
        end
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (BLOQUEO !== 1'b0 || BALANCE !== 64'd0) begin
            errors++;
            $display("FAIL block_reset: bloqueo=%b balance=%0d, required bloqueo=0 balance=0",
                     BLOQUEO, BALANCE);
        end
        remove_card();
    endtask

    task automatic test_reset_mid();
        int u0, f0;
        insert_card(); send_pin(16'h5916); send_tipo(1'b1);
        @(negedge Clk); #2 Reset = 1'b1;
        #1;
        checks++;
        if ({BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
             ADVERTENCIA, BLOQUEO} !== 6'b0 || BALANCE !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b balance=%0d, required flags=000000 balance=0",
                     {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
                      ADVERTENCIA, BLOQUEO}, BALANCE);
        end
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk);
        u0 = n_upd; f0 = n_fon;
        send_monto(32'd5000);
        send_tipo(1'b0);
        send_pin(16'h5916);
        send_monto(32'd5000);
        checks++;
        if (n_upd != u0 || n_fon != f0 || BALANCE !== 64'd0) begin
            errors++;
            $display("FAIL strobes_ignored: upd_pulses=%0d fon_pulses=%0d balance=%0d, required 0 0 0",
                     n_upd - u0, n_fon - f0, BALANCE);
        end
        send_tipo(1'b0); send_monto(32'd5000);
        checks++;
        if (BALANCE_ACTUALIZADO !== 1'b1 || BALANCE !== 64'd5000) begin
            errors++;
            $display("FAIL deposit_after_reset: upd=%b balance=%0d, required upd=1 balance=5000",
                     BALANCE_ACTUALIZADO, BALANCE);
        end
        remove_card();
    endtask

    task automatic test_warning_clear();
        int p0;
        p0 = n_pin;
        insert_card();
        send_pin(16'h6194); send_pin(16'h7195);
        checks++;
        if (ADVERTENCIA !== 1'b1 || n_pin - p0 != 2) begin
            errors++;
            $display("FAIL warn_set: adv=%b pulses=%0d, required adv=1 pulses=2", ADVERTENCIA, n_pin - p0);
        end
        hold_digit(4'h5, 3); send_digit(4'h9); send_digit(4'h1); send_digit(4'h6);
        checks++;
        if (ADVERTENCIA !== 1'b0 || n_pin - p0 != 2) begin
            errors++;
            $display("FAIL warn_clear: adv=%b pulses=%0d, required adv=0 pulses=2", ADVERTENCIA, n_pin - p0);
        end
        send_tipo(1'b0);
        send_pin(16'h5916);
        send_monto(32'd8000);
        checks++;
        if (BALANCE_ACTUALIZADO !== 1'b1 || BALANCE !== 64'd13000) begin
            errors++;
            $display("FAIL deposit_8000: upd=%b balance=%0d, required upd=1 balance=13000",
                     BALANCE_ACTUALIZADO, BALANCE);
        end
        remove_card();
    endtask

    task automatic test_back_to_back();
        int u0;
        insert_card(); send_pin(16'h5916); send_tipo(1'b0);
        u0 = n_upd;
        @(negedge Clk); MONTO = 32'd777; MONTO_STB = 1'b1;
        @(negedge Clk); MONTO_STB = 1'b0; TARJETA_RECIBIDA = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (n_upd != u0 || BALANCE !== 64'd13000) begin
            errors++;
            $display("FAIL removal_wins: upd_pulses=%0d balance=%0d, required 0 13000", n_upd - u0, BALANCE);
        end
        insert_card(); send_pin(16'h5916); send_tipo(1'b0); send_monto(32'd0);
        checks++;
        if (BALANCE_ACTUALIZADO !== 1'b1 || ENTREGAR_DINERO !== 1'b0 || BALANCE !== 64'd13000) begin
            errors++;
            $display("FAIL zero_amount: upd=%b ent=%b balance=%0d, required 1 0 13000",
                     BALANCE_ACTUALIZADO, ENTREGAR_DINERO, BALANCE);
        end
        remove_card();
        checks++;
        if (n_both != 0 || n_ent != 1 || n_fon != 1) begin
            errors++;
            $display("FAIL pulse_totals: overlap=%0d ent=%0d fon=%0d, required 0 1 1", n_both, n_ent, n_fon);
        end
    endtask

    initial begin
        test_reset();
        test_deposit();
        test_withdraw_ok();
        test_withdraw_nsf();
        test_lockout();
        test_reset_mid();
        test_warning_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
